// File: rtl/tsp_instruction_fetch.sv
// Instruction fetch front end for the TSP core: streams words out of the
// single-port instruction memory into a small prefetch FIFO feeding decode.
module tsp_instruction_fetch #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [5:0]        HALT_OP    = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              epoch;
  logic              in_flight;
  logic              in_flight_epoch;
  logic [ADDR_W-1:0] in_flight_pc;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              flush;
  logic [CNT_W-1:0]  credit_used;
  logic              issue;
  logic              enq;
  logic              deq;
  logic              halt_hit;

  // Start and redirect both restart the stream; neither issues a read that cycle.
  assign flush       = redirect_valid || start;
  assign credit_used = count + CNT_W'(in_flight);
  assign issue       = (state == S_FETCH) && !flush && (credit_used < DEPTH_C);

  // A returning word is kept only if it belongs to the current epoch and
  // fetching has not stopped or restarted since it was issued.
  assign enq      = in_flight && (in_flight_epoch == epoch) && (state == S_FETCH) && !flush;
  assign deq      = instr_valid && instr_ready;
  assign halt_hit = enq && (imem_rdata[DATA_W-1 -: 6] == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      pc              <= START_ADDR;
      epoch           <= 1'b0;
      in_flight       <= 1'b0;
      in_flight_epoch <= 1'b0;
      in_flight_pc    <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        in_flight_epoch <= epoch;
        in_flight_pc    <= pc;
      end

      if (redirect_valid) begin
        state <= S_FETCH;
        pc    <= redirect_addr;
        epoch <= ~epoch;
      end else if (start) begin
        state <= S_FETCH;
        pc    <= START_ADDR;
        epoch <= ~epoch;
      end else begin
        if (issue)    pc    <= pc + 1'b1;
        if (halt_hit) state <= S_HALT;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the FIFO storage has no reset; instr_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= in_flight_pc;
    end
  end

  assign imem_en     = issue;
  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  assign busy        = (state == S_FETCH);
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_tsp_instruction_fetch.sv
// Self-checking bench for tsp_instruction_fetch: a memory model answers reads,
// and a scoreboard of expected (pc, data) pairs is checked at every handshake.
module tb_tsp_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_addr = '0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [9:0]  instr_pc;
  logic        busy;
  logic        halted;

  tsp_instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] data;
  } exp_t;

  logic [31:0] mem [1024];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          popped   = 0;
  int          issues   = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic [9:0]  prev_pc    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory: registered read, data valid the cycle after imem_en.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  // Scoreboard, hold-stability and halt monitors, all sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_en) issues++;
    if (rst_n && halted && imem_en) check("en_while_halted", 32'(imem_en), 32'd0);
    if (prev_stall && rst_n && instr_valid) begin
      check("hold_data", instr_data, prev_data);
      check("hold_pc", 32'(instr_pc), 32'(prev_pc));
    end
    prev_stall = rst_n && instr_valid && !instr_ready && !redirect_valid && !start;
    prev_data  = instr_data;
    prev_pc    = instr_pc;
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word_pc", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", 32'(instr_pc), 32'(e.pc));
        check("sb_data", instr_data, e.data);
      end
      popped++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [9:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = first + 10'(i);
      e.data = mem[e.pc];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_popped(input string tag, input int n);
    int budget;
    budget = 0;
    while (popped < n && budget < 300) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check(tag, 32'(popped), 32'(n));
  endtask

  // Asynchronous reset asserted between clock edges; outputs checked before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    #1;
    check({tag, "_imem_en"},     32'(imem_en),     32'd0);
    check({tag, "_imem_addr"},   32'(imem_addr),   32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr_data"},  instr_data,       32'd0);
    check({tag, "_instr_pc"},    32'(instr_pc),    32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_halted"},      32'(halted),      32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    popped = 0;
    issues = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

    // 1: latency and one instruction per cycle with decode always ready.
    do_reset("t1_rst");
    instr_ready = 1'b1;
    tick();
    start = 1'b1;
    push_range(10'h000, 8);
    @(negedge clk);
    check("t1_en_c0", 32'(imem_en), 32'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t1_en_c1", 32'(imem_en), 32'd1);
    check("t1_addr_c1", 32'(imem_addr), 32'd0);
    check("t1_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_valid_c2", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_c3", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t1_stream_valid", 32'(instr_valid), 32'd1);
    end
    tick();
    instr_ready = 1'b0;
    check("t1_popped", 32'(popped), 32'd8);

    // 2: backpressure fills exactly FIFO_DEPTH, then drains without gaps.
    do_reset("t2_rst");
    tick();
    start = 1'b1;
    push_range(10'h000, 12);
    tick();
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_issues", 32'(issues), 32'd4);
    check("t2_en_stalled", 32'(imem_en), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", 32'(instr_pc), 32'd0);
    check("t2_head_data", instr_data, 32'h1000_0000);
    tick();
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t2_no_gap", 32'(instr_valid), 32'd1);
    end
    tick();
    instr_ready = 1'b0;
    check("t2_popped", 32'(popped), 32'd12);

    // 3: redirect with three words buffered and one read in flight.
    do_reset("t3_rst");
    tick();
    start = 1'b1;
    push_range(10'h000, 8);
    tick();
    start = 1'b0;
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_addr  = 10'h200;
    exp_q.delete();
    push_range(10'h200, 6);
    @(negedge clk);
    check("t3_issues_before", 32'(issues), 32'd4);
    check("t3_valid_before", 32'(instr_valid), 32'd1);
    check("t3_en_redirect", 32'(imem_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    check("t3_flushed", 32'(instr_valid), 32'd0);
    wait_popped("t3_popped", 6);
    instr_ready = 1'b0;

    // 4: HALT opcode at word 5 stops the stream; start restarts from HALT.
    mem[5] = 32'hFC00_0000;
    do_reset("t4_rst");
    instr_ready = 1'b1;
    tick();
    start = 1'b1;
    push_range(10'h000, 6);
    tick();
    start = 1'b0;
    wait_popped("t4_popped", 6);
    repeat (6) @(negedge clk);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid_after", 32'(instr_valid), 32'd0);
    check("t4_issues_le7", 32'(issues <= 7), 32'd1);
    tick();
    start = 1'b1;
    push_range(10'h000, 6);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t4_restart_busy", 32'(busy), 32'd1);
    check("t4_restart_halted", 32'(halted), 32'd0);
    wait_popped("t4_repopped", 12);
    repeat (6) @(negedge clk);
    check("t4_halted_again", 32'(halted), 32'd1);
    instr_ready = 1'b0;
    mem[5] = 32'h1000_0005;

    // 5: redirect near the top of the address space wraps the PC.
    do_reset("t5_rst");
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 10'h3FE;
    push_range(10'h3FE, 4);
    tick();
    redirect_valid = 1'b0;
    wait_popped("t5_popped", 4);
    instr_ready = 1'b0;

    // 6: reset mid-stream with a read in flight; nothing until a new start.
    do_reset("t6_rst0");
    instr_ready = 1'b1;
    tick();
    start = 1'b1;
    push_range(10'h000, 32);
    tick();
    start = 1'b0;
    wait_popped("t6_popped_pre", 3);
    @(negedge clk);
    check("t6_streaming", 32'(imem_en), 32'd1);
    do_reset("t6_rst_mid");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_idle_valid", 32'(instr_valid), 32'd0);
      check("t6_idle_en", 32'(imem_en), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    start = 1'b1;
    push_range(10'h000, 4);
    tick();
    start = 1'b0;
    wait_popped("t6_popped_post", 4);
    instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule
